// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {RUN, FLUSH} fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; used for both the instruction buffer and the PC queue.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited in-order requests, response buffering and redirect flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int             CW         = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    CREDIT_MAX = (CW+1)'(DEPTH);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc_q, pc_next;
    logic [CW-1:0]   inflight, inflight_next;
    logic [CW-1:0]   drop, drop_next;
    logic [CW-1:0]   fifo_count, pcq_count;
    logic            fifo_empty, fifo_full, pcq_empty, pcq_full;
    logic [CW:0]     credit_used;
    fetch_entry_t    entry_in, head;
    logic [XLEN-1:0] pcq_head;
    logic            fire, resp, resp_run, consume;

    assign credit_used    = {1'b0, inflight} + {1'b0, fifo_count};
    assign imem_req_valid = !reset && (state == RUN) && !redirect_valid && (credit_used < CREDIT_MAX);
    assign imem_req_addr  = pc_q;
    assign fire           = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp           = imem_resp_valid && (inflight != '0);
    assign resp_run       = resp && (state == RUN) && !redirect_valid;
    assign consume        = instr_valid && instr_ready;

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? NOP_INSTR : head.instr;
    assign instr_pc    = fifo_empty ? '0 : head.pc;
    assign entry_in    = '{instr: imem_resp_data, pc: pcq_head};

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_ibuf (
        .clk   (clk),
        .reset (reset),
        .push  (resp_run),
        .pop   (consume && !redirect_valid),
        .clear (redirect_valid),
        .wdata (entry_in),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pcq (
        .clk   (clk),
        .reset (reset),
        .push  (fire),
        .pop   (resp_run),
        .clear (redirect_valid),
        .wdata (pc_q),
        .rdata (pcq_head),
        .count (pcq_count),
        .empty (pcq_empty),
        .full  (pcq_full)
    );

    always_comb begin
        state_next    = state;
        pc_next       = pc_q;
        inflight_next = inflight;
        drop_next     = drop;
        if (redirect_valid) begin
            pc_next       = redirect_pc & ~32'h3;
            drop_next     = inflight - CW'(resp);
            inflight_next = drop_next;
            state_next    = (drop_next != '0) ? FLUSH : RUN;
        end else if (state == FLUSH) begin
            if (resp) begin
                inflight_next = inflight - CW'(1);
                drop_next     = drop - CW'(1);
                if (drop == CW'(1)) state_next = RUN;
            end
        end else begin
            if (fire) pc_next = pc_q + 32'd4;
            inflight_next = inflight + CW'(fire) - CW'(resp);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            pc_q     <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            state    <= state_next;
            pc_q     <= pc_next;
            inflight <= inflight_next;
            drop     <= drop_next;
        end
    end

    // Structural invariants guaranteed by the credit rule.
    a_resp_outstanding: assert property (@(posedge clk) disable iff (reset)
        !(imem_resp_valid && inflight == '0));
    a_pcq_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(fire && pcq_full && !resp_run));
    a_pcq_has_pc:       assert property (@(posedge clk) disable iff (reset) !(resp_run && pcq_empty));
    a_ibuf_no_overflow: assert property (@(posedge clk) disable iff (reset) !(resp_run && fifo_full && !consume));
    a_pcq_tracks:       assert property (@(posedge clk) disable iff (reset) (state != RUN) || (pcq_count == inflight));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with an in-order memory model and queue-based reference.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t        mem_q[$];
    fetch_entry_t ibuf_q[$];
    logic [31:0]  m_pc;
    int           cyc = 0;
    int           lat = 1;
    int           stall_pct = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [97:0]  obs_vec, exp_vec;
    bit           obs_fire, obs_iv;
    logic [31:0]  obs_addr, obs_ipc;

    task automatic do_reset();
        reset = 1'b1;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        mem_q.delete(); ibuf_q.delete();
        m_pc = RESET_PC; lat = 1; stall_pct = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: drive inputs, sample outputs, form expectation, then advance memory and model.
    task automatic tick(input bit rdy, input bit irdy, input bit redir, input logic [31:0] rpc);
        bit    resp, stale_any, exp_rv, consume;
        mreq_t e;
        imem_req_ready = rdy; instr_ready = irdy; redirect_valid = redir; redirect_pc = rpc;
        resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) >= stall_pct);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_q[0].data : $urandom;
        #1;
        stale_any = 1'b0;
        foreach (mem_q[i]) if (mem_q[i].stale) stale_any = 1'b1;
        exp_rv  = !redir && !stale_any && ((mem_q.size() + ibuf_q.size()) < DEPTH);
        obs_vec = {imem_req_valid, imem_req_valid ? imem_req_addr : 32'h0, instr_valid, instr, instr_pc};
        if (ibuf_q.size() > 0)
            exp_vec = {exp_rv, exp_rv ? m_pc : 32'h0, 1'b1, ibuf_q[0].instr, ibuf_q[0].pc};
        else
            exp_vec = {exp_rv, exp_rv ? m_pc : 32'h0, 1'b0, NOP_INSTR, 32'h0};
        obs_fire = imem_req_valid && rdy;
        obs_addr = imem_req_addr;
        obs_iv   = instr_valid;
        obs_ipc  = instr_pc;
        consume  = (ibuf_q.size() > 0) && irdy;
        @(posedge clk);
        if (resp) e = mem_q.pop_front();
        if (redir) begin
            ibuf_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (consume) void'(ibuf_q.pop_front());
            if (resp && !e.stale) ibuf_q.push_back('{instr: e.data, pc: e.addr});
        end
        if (obs_fire) begin
            mem_q.push_back('{addr: m_pc, data: $urandom, due: cyc + lat, stale: 1'b0});
            m_pc = m_pc + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        do_reset();
        reset = 1'b1;
        #1;
        n_checks++;
        if ({imem_req_valid, instr_valid, instr, instr_pc} !== {1'b0, 1'b0, NOP_INSTR, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs got rv=%0b iv=%0b instr=%h pc=%h, need 0 0 %h 0",
                     imem_req_valid, instr_valid, instr, instr_pc, NOP_INSTR);
        end
        @(negedge clk);
        reset = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (!(obs_fire && obs_addr === RESET_PC)) begin
            n_fail++;
            $display("FAIL first_req fire=%0b addr=%h, need 1 %h", obs_fire, obs_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int          first_iv = -1;
        int          seen = 0;
        logic [31:0] pcs [3];
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL stream cyc=%0d got %h exp %h", i, obs_vec, exp_vec);
            end
            if (obs_iv && first_iv < 0) first_iv = i;
            if (obs_iv && seen < 3) begin pcs[seen] = obs_ipc; seen++; end
        end
        n_checks++;
        if (first_iv !== 2) begin
            n_fail++;
            $display("FAIL stream_latency first instr_valid at %0d, need 2", first_iv);
        end
        n_checks++;
        if ({pcs[0], pcs[1], pcs[2]} !== {32'h0, 32'h4, 32'h8}) begin
            n_fail++;
            $display("FAIL stream_pcs got %h %h %h, need 0 4 8", pcs[0], pcs[1], pcs[2]);
        end
    endtask

    task automatic test_backpressure();
        int fires = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, i >= 10, 1'b0, 32'h0);
            if (i < 10) fires += int'(obs_fire);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL backpressure cyc=%0d got %h exp %h", i, obs_vec, exp_vec);
            end
        end
        n_checks++;
        if (fires !== DEPTH) begin
            n_fail++;
            $display("FAIL backpressure_credit got %0d requests, need %0d", fires, DEPTH);
        end
    endtask

    task automatic test_ready_toggle();
        do_reset();
        lat = 2;
        for (int i = 0; i < 16; i++) begin
            tick(i % 2 == 0, 1'b1, 1'b0, 32'h0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL ready_toggle cyc=%0d got %h exp %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_redirect_inflight();
        logic [31:0] first_pc = 32'hdead_beef;
        bit          got = 1'b0;
        do_reset();
        lat = 3;
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL redirect_inflight cyc=%0d got %h exp %h", i, obs_vec, exp_vec);
            end
            if (obs_iv && !got) begin first_pc = obs_ipc; got = 1'b1; end
        end
        n_checks++;
        if (first_pc !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL redirect_first_pc got %h, need 00000100", first_pc);
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0203);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL redirect_full got %h exp %h", obs_vec, exp_vec);
        end
        n_checks++;
        if (!(obs_fire && obs_addr === 32'h0000_0200 && !obs_iv)) begin
            n_fail++;
            $display("FAIL redirect_full_req fire=%0b addr=%h iv=%0b, need 1 00000200 0",
                     obs_fire, obs_addr, obs_iv);
        end
    endtask

    task automatic test_wrap();
        bit          saw_wrap = 1'b0;
        logic [31:0] prev = 32'h1;
        do_reset();
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL wrap cyc=%0d got %h exp %h", i, obs_vec, exp_vec);
            end
            if (obs_fire) begin
                if (prev == 32'hFFFF_FFFC && obs_addr === 32'h0) saw_wrap = 1'b1;
                prev = obs_addr;
            end
        end
        n_checks++;
        if (!saw_wrap) begin
            n_fail++;
            $display("FAIL wrap_addr last=%h, need FFFFFFFC followed by 00000000", prev);
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        lat = 6;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0400);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        imem_resp_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({imem_req_valid, instr_valid, instr, instr_pc} !== {1'b0, 1'b0, NOP_INSTR, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_mid_flush got rv=%0b iv=%0b instr=%h pc=%h",
                     imem_req_valid, instr_valid, instr, instr_pc);
        end
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        n_checks++;
        if (!(obs_fire && obs_addr === RESET_PC)) begin
            n_fail++;
            $display("FAIL reset_mid_flush_req fire=%0b addr=%h, need 1 %h", obs_fire, obs_addr, RESET_PC);
        end
    endtask

    task automatic test_random();
        do_reset();
        stall_pct = 25;
        for (int i = 0; i < 400; i++) begin
            bit rd, ir, rv;
            rd  = ($urandom_range(3) != 0);
            ir  = ($urandom_range(2) != 0);
            rv  = ($urandom_range(24) == 0);
            lat = 1 + $urandom_range(3);
            tick(rd, ir, rv, $urandom);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random cyc=%0d got %h exp %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_ready_toggle();
        test_redirect_inflight();
        test_redirect_full();
        test_wrap();
        test_reset_mid_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage; sits directly upstream of the instruction decoder.
- Holds the fetch PC and issues in-order word requests to instruction memory over a valid/ready handshake.
- Buffers returned words in a small FIFO and presents {instr, pc} to the decoder with valid/ready.
- Supports a redirect (branch/jump) that flushes buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 4, FIFO entries and also the max (in-flight + buffered) credit; power of two, >= 2

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  32  word address of request (bits [1:0] always 0)
imem_resp_valid  in  1  response word valid; in request order; latency >= 1 cycle; no backpressure
imem_resp_data  in  32  response instruction word
redirect_valid  in  1  redirect fetch this cycle
redirect_pc  in  32  new fetch PC ([1:0] ignored and forced to 0)
instr_valid  out  1  buffered instruction available
instr_ready  in  1  decoder consumes instruction
instr  out  32  instruction word to decoder
instr_pc  out  32  PC of instr

Behaviour:
- Reset (async assert, sync deassert by the system):
  - pc_q = RESET_PC; FIFO empty; inflight = 0; drop = 0; state = RUN.
  - Outputs: imem_req_valid = 0, instr_valid = 0, instr = 32'h0000_0013 (NOP), instr_pc = 0.
- States:
  - RUN: normal fetch.
  - FLUSH: discarding stale responses.
- Credit rule: imem_req_valid = (state==RUN) && !redirect_valid && (inflight + fifo_count < DEPTH).
- imem_req_addr = pc_q.
- Handshake:
  - A request fires when imem_req_valid && imem_req_ready.
  - On fire: pc_q += 4 (wraps modulo 2^32), inflight++, and the address is pushed into an internal PC queue (DEPTH entries).
- Response:
  - On imem_resp_valid in RUN: pop the PC queue, push {data, pc} into the FIFO, inflight--.
  - The new entry is visible on instr_* the next cycle (no bypass).
  - Minimum request-to-instr_valid latency is memory latency + 1.
- Output side:
  - instr_valid = FIFO non-empty; instr/instr_pc = head entry.
  - When the FIFO is empty: instr = NOP, instr_pc = 0.
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle are allowed; count unchanged.
- The FIFO can never overflow because of the credit rule. imem_resp_valid with inflight==0 is a protocol error; assert in simulation, ignore in RTL.
- Redirect (takes priority over everything):
  - Next cycle: pc_q = {redirect_pc[31:2],2'b00}; FIFO and PC queue cleared; no pop.
  - Any response arriving in the redirect cycle is discarded.
  - drop = inflight − (resp_valid this cycle ? 1 : 0); inflight = drop.
  - A request is never issued in the redirect cycle.
  - Next state = FLUSH if drop != 0, else RUN.
- FLUSH:
  - No requests issued.
  - Each imem_resp_valid decrements drop and inflight; the data is discarded.
  - When drop reaches 0 (on the decrementing cycle), go to RUN; requests resume the following cycle.
- A redirect during FLUSH restarts the computation above with the current inflight; the last redirect wins.
- A redirect while instr_valid && instr_ready in the same cycle: the consume is still reported to the decoder, and the FIFO is cleared anyway.
- Reset mid-operation: all state returns to reset values immediately; responses arriving after reset deassert that belong to pre-reset requests are the system's responsibility (memory is reset together).

Decomposition:
- Package fetch_pkg:
  - XLEN = 32
  - NOP_INSTR = 32'h0000_0013
  - typedef enum {RUN, FLUSH} fetch_state_t
  - typedef struct packed {logic [31:0] instr; logic [31:0] pc;} fetch_entry_t
- Sub-module fetch_fifo:
  - Parameterised synchronous FIFO (DEPTH, payload width) with push/pop/clear, count, empty/full.
  - Instantiated twice: once for the entry buffer, once for the PC queue.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory, instr_ready=1:
  - Requests at 0x0, 0x4, 0x8…
  - instr_valid first high 2 cycles after first request; instr_pc sequence 0x0, 0x4, 0x8.
- instr_ready=0 for 10 cycles, memory latency 1:
  - Exactly DEPTH=4 requests issued, then imem_req_valid low.
  - FIFO holds PCs 0x0–0xC; release drains them in order.
- imem_req_ready toggling 1,0,1,0:
  - imem_req_addr holds stable while ready=0; no PC skipped or duplicated.
- Memory latency 3, 2 requests in flight, redirect_pc=0x100:
  - Two following responses discarded (FLUSH for 2 responses).
  - Next request addr 0x100; first instr_pc seen = 0x100.
- Redirect with 0 in flight and a full FIFO:
  - instr_valid low next cycle; stays RUN; request to redirect_pc issued the cycle after redirect.
- pc_q=0xFFFF_FFFC fetch → next request addr 0x0000_0000 (wrap).
- Reset asserted mid-FLUSH → outputs at reset values same cycle.
- First request after deassert is at RESET_PC.
